// File: rtl/axis_rr_fifo_arbiter_if.sv
// Bus bundle for the round-robin FIFO arbiter: NUM_IN packed AXIS inputs and one FIFO write port.
// Latency: none (wires only).
// Backpressure: per-stream tready on the input side; the FIFO write side has no tready.
interface axis_rr_fifo_arbiter_if #(
    parameter int NUM_IN     = 4,
    parameter int DATA_WIDTH = 16,
    parameter int USER_WIDTH = 1
);
    localparam int IDW = ($clog2(NUM_IN) > 1) ? $clog2(NUM_IN) : 1;
    // Zero-width tuser is carried as one dummy bit per stream so the bus stays legal.
    localparam int UWI = (USER_WIDTH > 0) ? USER_WIDTH : 1;

    // Input streams, stream k occupies slice k of every packed vector.
    logic [NUM_IN*DATA_WIDTH-1:0] s_axis_in_tdata;
    logic [NUM_IN*UWI-1:0]        s_axis_in_tuser;
    logic [NUM_IN-1:0]            s_axis_in_tlast;
    logic [NUM_IN-1:0]            s_axis_in_tvalid;
    logic [NUM_IN-1:0]            s_axis_in_tready;

    // FIFO write port, tuser = {source index, stream tuser}.
    logic [DATA_WIDTH-1:0]        m_axis_out_tdata;
    logic [USER_WIDTH+IDW-1:0]    m_axis_out_tuser;
    logic                         m_axis_out_tvalid;

    // The arbiter masters the FIFO write port and owns the input readies.
    modport master (
        input  s_axis_in_tdata,
        input  s_axis_in_tuser,
        input  s_axis_in_tlast,
        input  s_axis_in_tvalid,
        output s_axis_in_tready,
        output m_axis_out_tdata,
        output m_axis_out_tuser,
        output m_axis_out_tvalid
    );

    // Environment side: stream sources and the FIFO.
    modport slave (
        output s_axis_in_tdata,
        output s_axis_in_tuser,
        output s_axis_in_tlast,
        output s_axis_in_tvalid,
        input  s_axis_in_tready,
        input  m_axis_out_tdata,
        input  m_axis_out_tuser,
        input  m_axis_out_tvalid
    );
endinterface

// File: rtl/axis_rr_fifo_arbiter.sv
// Round-robin burst arbiter feeding one FIFO write port from NUM_IN streams, tagging beats with the source index.
// Latency: 1 cycle accept-to-write; one idle arbitration bubble between grants.
// Backpressure: granted stream's tready drops combinationally on FIFO full or level >= FIFO_LEN-AF_MARGIN.
module axis_rr_fifo_arbiter #(
    parameter int NUM_IN     = 4,
    parameter int DATA_WIDTH = 16,
    parameter int USER_WIDTH = 1,
    parameter int FIFO_LEN   = 8,
    parameter int AF_MARGIN  = 2,
    parameter int MAX_BURST  = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    axis_rr_fifo_arbiter_if.master      bus,
    input  logic [$clog2(FIFO_LEN)-1:0] fifo_tlevel_i,
    input  logic                        fifo_tfull_i,
    output logic [NUM_IN-1:0]           grant_o,
    output logic                        overflow_o
);
    localparam int IDW      = ($clog2(NUM_IN) > 1) ? $clog2(NUM_IN) : 1;
    localparam int UWI      = (USER_WIDTH > 0) ? USER_WIDTH : 1;
    localparam int OUW      = USER_WIDTH + IDW;
    localparam int CW       = $clog2(MAX_BURST + 1);
    localparam int AF_LEVEL = FIFO_LEN - AF_MARGIN;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    // Arbitration state
    state_t                r_state;
    logic [IDW-1:0]        r_idx;          // stream currently granted
    logic [IDW-1:0]        r_rr_ptr;       // last stream that finished a burst
    logic [CW-1:0]         r_beat_cnt;     // beats accepted in the current grant
    logic [NUM_IN-1:0]     r_grant;

    // Output register towards the FIFO
    logic                  r_out_vld;
    logic [DATA_WIDTH-1:0] r_out_dat;
    logic [OUW-1:0]        r_out_usr;
    logic                  r_overflow;

    // Combinational helpers
    logic                  w_throttle;
    logic                  w_req_vld;
    logic                  w_req_last;
    logic [DATA_WIDTH-1:0] w_req_dat;
    logic [UWI-1:0]        w_req_usr;
    logic [OUW-1:0]        w_out_usr_nxt;
    logic                  w_grant_ok;
    logic                  w_accept;
    logic                  w_burst_end;
    logic [NUM_IN-1:0]     w_tready;
    logic                  w_pick_found;
    logic [IDW-1:0]        w_pick_idx;
    logic [IDW-1:0]        w_scan_idx;
    logic [NUM_IN-1:0]     w_pick_onehot;

    // The level input wraps to 0 when the FIFO is full, so full must always be ORed in.
    // The margin absorbs the one-cycle lag between our write strobe and the FIFO's registered level.
    assign w_throttle = fifo_tfull_i | (int'(fifo_tlevel_i) >= AF_LEVEL);

    // Select the granted stream's beat with constant-index slices.
    always_comb begin
        w_req_vld  = 1'b0;
        w_req_last = 1'b0;
        w_req_dat  = '0;
        w_req_usr  = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (r_idx == IDW'(k)) begin
                w_req_vld  = bus.s_axis_in_tvalid[k];
                w_req_last = bus.s_axis_in_tlast[k];
                w_req_dat  = bus.s_axis_in_tdata[k*DATA_WIDTH +: DATA_WIDTH];
                w_req_usr  = bus.s_axis_in_tuser[k*UWI +: UWI];
            end
        end
    end

    // Tag each beat with its source index; with no stream tuser the tag is the whole field.
    generate
        if (USER_WIDTH > 0) begin : g_usr
            assign w_out_usr_nxt = {r_idx, w_req_usr[USER_WIDTH-1:0]};
        end else begin : g_no_usr
            assign w_out_usr_nxt = r_idx;
        end
    endgenerate

    // Only the granted stream may see tready, and never while reset is asserted.
    assign w_grant_ok  = (r_state == S_GRANT) && !reset_i && !w_throttle;
    assign w_accept    = w_grant_ok && w_req_vld;
    assign w_burst_end = w_req_last || (r_beat_cnt == CW'(MAX_BURST - 1));

    // Drive the one-hot per-stream ready.
    always_comb begin
        w_tready = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            w_tready[k] = w_grant_ok && (r_idx == IDW'(k));
        end
    end

    assign bus.s_axis_in_tready = w_tready;

    // Round-robin scan: first valid stream starting just after the last one served.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_scan_idx   = '0;
        for (int i = 1; i <= NUM_IN; i++) begin
            w_scan_idx = IDW'((int'(r_rr_ptr) + i) % NUM_IN);
            if (!w_pick_found && bus.s_axis_in_tvalid[w_scan_idx]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_scan_idx;
            end
        end
    end

    // One-hot form of the pick, loaded into the registered grant.
    always_comb begin
        w_pick_onehot = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            w_pick_onehot[k] = (w_pick_idx == IDW'(k));
        end
    end

    // Arbiter FSM: IDLE picks a stream, GRANT holds it until tlast or the burst limit.
    // A granted stream that stalls keeps the grant so packets are never interleaved.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_rr_ptr   <= IDW'(NUM_IN - 1);
            r_beat_cnt <= '0;
            r_grant    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_found) begin
                        r_state    <= S_GRANT;
                        r_idx      <= w_pick_idx;
                        r_grant    <= w_pick_onehot;
                        r_beat_cnt <= '0;
                    end
                end
                S_GRANT: begin
                    if (w_accept) begin
                        if (w_burst_end) begin
                            r_state    <= S_IDLE;
                            r_rr_ptr   <= r_idx;
                            r_grant    <= '0;
                            r_beat_cnt <= '0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Register accepted beats into the FIFO write port; data/tuser hold between writes.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
            r_out_usr <= '0;
        end else begin
            r_out_vld <= w_accept;
            if (w_accept) begin
                r_out_dat <= w_req_dat;
                r_out_usr <= w_out_usr_nxt;
            end
        end
    end

    // Sticky flag: a write strobe landed while the FIFO reported full.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_overflow <= 1'b0;
        end else if (r_out_vld && fifo_tfull_i) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.m_axis_out_tvalid = r_out_vld;
    assign bus.m_axis_out_tdata  = r_out_dat;
    assign bus.m_axis_out_tuser  = r_out_usr;
    assign grant_o               = r_grant;
    assign overflow_o            = r_overflow;

    // Structural invariants of the grant logic.
    a_tready_onehot0: assert property (@(posedge clk_i) disable iff (reset_i)
        $onehot0(bus.s_axis_in_tready));
    a_grant_onehot0: assert property (@(posedge clk_i) disable iff (reset_i)
        $onehot0(r_grant));
    a_idle_no_grant: assert property (@(posedge clk_i) disable iff (reset_i)
        (r_state == S_IDLE) |-> (r_grant == '0));
    a_beat_cnt_range: assert property (@(posedge clk_i) disable iff (reset_i)
        int'(r_beat_cnt) < MAX_BURST);
endmodule

// File: tb/tb_axis_rr_fifo_arbiter.sv
module tb_axis_rr_fifo_arbiter;
    localparam int NUM_IN = 4;
    localparam int DW     = 16;
    localparam int UW     = 1;

    typedef logic [18:0] beat_t;  // {tdata[15:0], idx[1:0], tuser}

    logic       clk;
    logic       reset_i;
    logic [2:0] fifo_tlevel_i;
    logic       fifo_tfull_i;
    logic [3:0] grant_o;
    logic       overflow_o;

    axis_rr_fifo_arbiter_if #(.NUM_IN(NUM_IN), .DATA_WIDTH(DW), .USER_WIDTH(UW)) bus ();

    axis_rr_fifo_arbiter #(
        .NUM_IN(NUM_IN), .DATA_WIDTH(DW), .USER_WIDTH(UW),
        .FIFO_LEN(8), .AF_MARGIN(2), .MAX_BURST(4)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .bus(bus),
        .fifo_tlevel_i(fifo_tlevel_i),
        .fifo_tfull_i(fifo_tfull_i),
        .grant_o(grant_o),
        .overflow_o(overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_chk  = 0;
    int    n_fail = 0;
    beat_t exp_q[$];

    // Source model: stream k beat n carries data k*16+n+1, tuser n[0]; pkt_left 0 = endless.
    logic [3:0] src_en;
    int         src_cnt[NUM_IN];
    int         pkt_left[NUM_IN];
    logic [3:0] last_hs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NUM_IN; k++) begin
            bus.s_axis_in_tdata[k*DW +: DW] = 16'(k*16 + src_cnt[k] + 1);
            bus.s_axis_in_tuser[k]          = src_cnt[k][0];
            bus.s_axis_in_tlast[k]          = (pkt_left[k] == 1);
        end
        bus.s_axis_in_tvalid = src_en;
    endtask

    // One clock: sample handshakes mid-cycle, then advance the sources just after the edge.
    task automatic tick();
        logic [3:0] hs;
        @(negedge clk);
        hs = bus.s_axis_in_tvalid & bus.s_axis_in_tready;
        @(posedge clk);
        #1;
        last_hs = hs;
        for (int k = 0; k < NUM_IN; k++) begin
            if (hs[k]) begin
                src_cnt[k]++;
                if (pkt_left[k] != 0) begin
                    pkt_left[k]--;
                    if (pkt_left[k] == 0) src_en[k] = 1'b0;
                end
            end
        end
        drive();
    endtask

    task automatic exp_beats(input int k, input int n0, input int cnt);
        for (int n = n0; n < n0 + cnt; n++) begin
            exp_q.push_back({16'(k*16 + n + 1), 2'(k), 1'(n & 1)});
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        src_en  = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            src_cnt[k]  = 0;
            pkt_left[k] = 0;
        end
        drive();
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(src_en == 4'b0 && grant_o == 4'b0) && n < 200) begin
            tick();
            n++;
        end
        chk({name, "_idle_in_time"}, 32'(n < 200), 32'd1);
        tick();
        tick();
        chk({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard monitor: every FIFO write must match the next expected beat.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (bus.m_axis_out_tvalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got beat 0x%0h, want no write at %0t",
                             {bus.m_axis_out_tdata, bus.m_axis_out_tuser}, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_beat", 32'({bus.m_axis_out_tdata, bus.m_axis_out_tuser}), 32'(e));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacc;
        reset_i       = 1'b1;
        fifo_tlevel_i = 3'd0;
        fifo_tfull_i  = 1'b0;
        last_hs       = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            src_cnt[k]  = 0;
            pkt_left[k] = 0;
        end
        src_en = 4'b1111;
        drive();
        tick();
        tick();

        // Reset state, tready forced low even with every stream valid
        chk("rst_tready", 32'(bus.s_axis_in_tready), 32'h0);
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_tvalid", 32'(bus.m_axis_out_tvalid), 32'h0);
        chk("rst_tdata", 32'(bus.m_axis_out_tdata), 32'h0);
        chk("rst_tuser", 32'(bus.m_axis_out_tuser), 32'h0);
        chk("rst_overflow", 32'(overflow_o), 32'h0);

        // Test 1: stream 0 alone, 3-beat packet
        src_en      = 4'b0001;
        pkt_left[0] = 3;
        drive();
        exp_beats(0, 0, 3);
        reset_i = 1'b0;
        #1 chk("t1_bubble_tready", 32'(bus.s_axis_in_tready), 32'h0);
        tick();
        chk("t1_grant", 32'(grant_o), 32'h1);
        nacc = 0;
        for (int c = 0; c < 7; c++) begin
            tick();
            if (last_hs[0]) begin
                nacc++;
                chk("t1_write_latency", 32'(bus.m_axis_out_tvalid), 32'h1);
            end
        end
        chk("t1_beats", 32'(nacc), 32'd3);
        chk("t1_idle_grant", 32'(grant_o), 32'h0);
        wait_idle("t1");

        // Test 2: all streams valid, no tlast: grants 0,1,2,3,0 with 4 beats and one bubble
        do_reset();
        src_en = 4'b1111;
        drive();
        exp_beats(0, 0, 4);
        exp_beats(1, 0, 4);
        exp_beats(2, 0, 4);
        exp_beats(3, 0, 4);
        exp_beats(0, 4, 4);
        for (int n = 1; n <= 25; n++) begin
            logic [3:0] eg;
            tick();
            eg = ((n - 1) % 5 == 4) ? 4'b0 : 4'(1 << (((n - 1) / 5) % 4));
            if (n == 25) begin
                src_en = 4'b0;
                drive();
                #1;
            end
            chk("t2_grant_seq", 32'(grant_o), 32'(eg));
            chk("t2_tready_seq", 32'(bus.s_axis_in_tready), 32'(eg));
        end
        wait_idle("t2");

        // Test 3: almost-full threshold mid-burst
        do_reset();
        src_en      = 4'b0001;
        pkt_left[0] = 4;
        drive();
        exp_beats(0, 0, 4);
        tick();
        tick();
        fifo_tlevel_i = 3'd6;
        #1 chk("t3_level6_tready", 32'(bus.s_axis_in_tready), 32'h0);
        chk("t3_grant_held", 32'(grant_o), 32'h1);
        tick();
        chk("t3_no_write", 32'(bus.m_axis_out_tvalid), 32'h0);
        fifo_tlevel_i = 3'd7;
        #1 chk("t3_level7_tready", 32'(bus.s_axis_in_tready), 32'h0);
        tick();
        fifo_tlevel_i = 3'd5;
        #1 chk("t3_level5_tready", 32'(bus.s_axis_in_tready), 32'h1);
        wait_idle("t3");
        fifo_tlevel_i = 3'd0;

        // Test 4: full with wrapped level 0, then a write lands under full
        do_reset();
        fifo_tfull_i = 1'b1;
        src_en       = 4'b0010;
        pkt_left[1]  = 4;
        drive();
        exp_beats(1, 0, 4);
        tick();
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t4_full_tready", 32'(bus.s_axis_in_tready), 32'h0);
            chk("t4_full_no_write", 32'(bus.m_axis_out_tvalid), 32'h0);
        end
        chk("t4_grant", 32'(grant_o), 32'h2);
        fifo_tfull_i = 1'b0;
        tick();
        chk("t4_write", 32'(bus.m_axis_out_tvalid), 32'h1);
        chk("t4_ovf_before", 32'(overflow_o), 32'h0);
        fifo_tfull_i = 1'b1;
        tick();
        chk("t4_ovf_set", 32'(overflow_o), 32'h1);
        fifo_tfull_i = 1'b0;
        wait_idle("t4");
        chk("t4_ovf_sticky", 32'(overflow_o), 32'h1);

        // Test 5: granted stream 2 stalls 5 cycles while others request
        do_reset();
        chk("t5_ovf_cleared", 32'(overflow_o), 32'h0);
        src_en      = 4'b0100;
        pkt_left[2] = 4;
        drive();
        exp_beats(2, 0, 4);
        exp_beats(3, 0, 4);
        exp_beats(0, 0, 4);
        exp_beats(1, 0, 4);
        tick();
        tick();
        src_en      = 4'b1011;
        pkt_left[0] = 4;
        pkt_left[1] = 4;
        pkt_left[3] = 4;
        drive();
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t5_grant_held", 32'(grant_o), 32'h4);
            chk("t5_tready_held", 32'(bus.s_axis_in_tready), 32'h4);
            tick();
        end
        src_en[2] = 1'b1;
        drive();
        wait_idle("t5");

        // Test 6: reset pulse on the 2nd beat of a burst
        src_en      = 4'b0100;
        pkt_left[2] = 4;
        drive();
        exp_beats(2, 4, 4);
        wait_idle("t6a");
        src_en      = 4'b0010;
        pkt_left[1] = 4;
        drive();
        exp_beats(1, 4, 1);
        exp_beats(0, 4, 4);
        exp_beats(1, 5, 3);
        exp_beats(3, 4, 4);
        tick();
        chk("t6_grant1", 32'(grant_o), 32'h2);
        tick();
        reset_i     = 1'b1;
        src_en      = 4'b1011;
        pkt_left[0] = 4;
        pkt_left[3] = 4;
        drive();
        #1 chk("t6_rst_tready", 32'(bus.s_axis_in_tready), 32'h0);
        tick();
        chk("t6_rst_grant", 32'(grant_o), 32'h0);
        chk("t6_rst_tvalid", 32'(bus.m_axis_out_tvalid), 32'h0);
        chk("t6_rst_tdata", 32'(bus.m_axis_out_tdata), 32'h0);
        reset_i = 1'b0;
        tick();
        chk("t6_rr_restart", 32'(grant_o), 32'h1);
        wait_idle("t6b");

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
